// File: rtl/cacheline_adapter.sv
// Adapts 256-bit cache line reads and writes into BURST_LEN-beat bursts on the bmem bus.
// Define CLA_RADDR_CHECK_EN to drop returning read beats whose bmem_raddr tag does not match the burst address.
//
// state    | meaning
// IDLE     | waiting for dfp_read / dfp_write (write wins)
// RD_REQ   | bmem_read held until memory accepts the command
// RD_WAIT  | collecting BURST_LEN read beats into dfp_rdata
// WR_BURST | presenting write beats, advancing on bmem_ready
// RESP     | dfp_resp pulse, then back to IDLE
module cacheline_adapter #(
   parameter int BURST_LEN  = 4,
   parameter int BEAT_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           dfp_addr,
   input  logic                  dfp_read,
   input  logic                  dfp_write,
   input  logic [255:0]          dfp_wdata,
   output logic [255:0]          dfp_rdata,
   output logic                  dfp_resp,
   output logic [31:0]           bmem_addr,
   output logic                  bmem_read,
   output logic                  bmem_write,
   output logic [BEAT_WIDTH-1:0] bmem_wdata,
   input  logic                  bmem_ready,
   input  logic [31:0]           bmem_raddr,
   input  logic [BEAT_WIDTH-1:0] bmem_rdata,
   input  logic                  bmem_rvalid
);

   localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] RD_REQ   = 3'd1;
   localparam logic [2:0] RD_WAIT  = 3'd2;
   localparam logic [2:0] WR_BURST = 3'd3;
   localparam logic [2:0] RESP     = 3'd4;

   logic [2:0]    state;
   logic [CW-1:0] cnt;
   logic [255:0]  line_q;
   logic          beat_ok;
   logic          unused_bits;

`ifdef CLA_RADDR_CHECK_EN
   assign beat_ok = bmem_rvalid && (bmem_raddr == bmem_addr);
`else
   assign beat_ok = bmem_rvalid;
`endif

   assign unused_bits = ^{dfp_addr[4:0], bmem_raddr};

   // bmem_addr doubles as the latched line address; line_q holds the beats still to be sent.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         line_q     <= '0;
         dfp_rdata  <= '0;
         dfp_resp   <= 1'b0;
         bmem_addr  <= '0;
         bmem_read  <= 1'b0;
         bmem_write <= 1'b0;
         bmem_wdata <= '0;
      end else begin
         dfp_resp <= 1'b0;
         case (state)
            IDLE: begin
               if (dfp_write) begin
                  bmem_addr  <= {dfp_addr[31:5], 5'b0};
                  bmem_write <= 1'b1;
                  bmem_wdata <= dfp_wdata[BEAT_WIDTH-1:0];
                  line_q     <= dfp_wdata >> BEAT_WIDTH;
                  cnt        <= '0;
                  state      <= WR_BURST;
               end else if (dfp_read) begin
                  bmem_addr <= {dfp_addr[31:5], 5'b0};
                  bmem_read <= 1'b1;
                  cnt       <= '0;
                  state     <= RD_REQ;
               end
            end
            RD_REQ: begin
               if (bmem_ready) begin
                  bmem_read <= 1'b0;
                  state     <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               // Beats shift in from the top so beat 0 ends up in the low word.
               if (beat_ok) begin
                  dfp_rdata <= {bmem_rdata, dfp_rdata[255:BEAT_WIDTH]};
                  if (cnt == LAST) begin
                     cnt      <= '0;
                     dfp_resp <= 1'b1;
                     state    <= RESP;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            WR_BURST: begin
               if (bmem_ready) begin
                  if (cnt == LAST) begin
                     bmem_write <= 1'b0;
                     cnt        <= '0;
                     dfp_resp   <= 1'b1;
                     state      <= RESP;
                  end else begin
                     bmem_wdata <= line_q[BEAT_WIDTH-1:0];
                     line_q     <= line_q >> BEAT_WIDTH;
                     cnt        <= cnt + 1'b1;
                  end
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed bench for cacheline_adapter: reads, writes, stalls, read/write collision, async reset, raddr tags.
module tb_cacheline_adapter;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  dfp_addr;
   logic         dfp_read;
   logic         dfp_write;
   logic [255:0] dfp_wdata;
   logic [255:0] dfp_rdata;
   logic         dfp_resp;
   logic [31:0]  bmem_addr;
   logic         bmem_read;
   logic         bmem_write;
   logic [63:0]  bmem_wdata;
   logic         bmem_ready;
   logic [31:0]  bmem_raddr;
   logic [63:0]  bmem_rdata;
   logic         bmem_rvalid;

   int vecs = 0;
   int miss = 0;

   localparam logic [255:0] LINE_R1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                       64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
   localparam logic [255:0] LINE_W1 = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                       64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
   localparam logic [255:0] LINE_W2 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                       64'h5555_AAAA_5555_AAAA, 64'h0F0F_0F0F_F0F0_F0F0};
   localparam logic [255:0] LINE_R2 = {64'h8888_0000_0000_0008, 64'h7777_0000_0000_0007,
                                       64'h6666_0000_0000_0006, 64'h5555_0000_0000_0005};
   localparam logic [255:0] LINE_R3 = {64'hA3A3_A3A3_0000_0004, 64'hA2A2_A2A2_0000_0003,
                                       64'hA1A1_A1A1_0000_0002, 64'hA0A0_A0A0_0000_0001};

   cacheline_adapter #(.BURST_LEN(4), .BEAT_WIDTH(64)) dut (
      .clk        (clk),
      .rst        (rst),
      .dfp_addr   (dfp_addr),
      .dfp_read   (dfp_read),
      .dfp_write  (dfp_write),
      .dfp_wdata  (dfp_wdata),
      .dfp_rdata  (dfp_rdata),
      .dfp_resp   (dfp_resp),
      .bmem_addr  (bmem_addr),
      .bmem_read  (bmem_read),
      .bmem_write (bmem_write),
      .bmem_wdata (bmem_wdata),
      .bmem_ready (bmem_ready),
      .bmem_raddr (bmem_raddr),
      .bmem_rdata (bmem_rdata),
      .bmem_rvalid(bmem_rvalid)
   );

   always #5 clk = ~clk;

   // Read burst: command, then four beats (optionally with a mistagged beat before beat 2).
   task automatic read_burst(input string name, input logic [31:0] addr, input logic [31:0] exp_aligned,
                             input logic [255:0] line, input logic [31:0] beat_tag, input bit stray);
      dfp_read = 1'b1;
      dfp_addr = addr;
      bmem_ready = 1'b1;
      @(posedge clk); #1;
      vecs++;
      if (bmem_read !== 1'b1 || bmem_addr !== exp_aligned) begin
         miss++;
         $display("FAIL %s cmd: got read=%0b addr=%h expected read=1 addr=%h", name, bmem_read, bmem_addr, exp_aligned);
      end
      @(posedge clk); #1;
      vecs++;
      if (bmem_read !== 1'b0) begin
         miss++;
         $display("FAIL %s cmd_drop: got read=%0b expected 0", name, bmem_read);
      end
      for (int i = 0; i < 4; i++) begin
         if (stray && i == 2) begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = 32'hDEAD_0000;
            bmem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
            @(posedge clk); #1;
         end
         bmem_rvalid = 1'b1;
         bmem_raddr  = beat_tag;
         bmem_rdata  = line[64*i +: 64];
         @(posedge clk); #1;
         if (i < 3) begin
            vecs++;
            if (dfp_resp !== 1'b0 || bmem_read !== 1'b0) begin
               miss++;
               $display("FAIL %s beat%0d: got resp=%0b read=%0b expected 0 0", name, i, dfp_resp, bmem_read);
            end
         end
      end
      bmem_rvalid = 1'b0;
      vecs++;
      if (dfp_resp !== 1'b1) begin
         miss++;
         $display("FAIL %s resp: got %0b expected 1", name, dfp_resp);
      end
      vecs++;
      if (dfp_rdata !== line) begin
         miss++;
         $display("FAIL %s rdata: got %h expected %h", name, dfp_rdata, line);
      end
      dfp_read = 1'b0;
      @(posedge clk); #1;
      vecs++;
      if (dfp_resp !== 1'b0 || dfp_rdata !== line) begin
         miss++;
         $display("FAIL %s after_resp: got resp=%0b rdata=%h expected 0 %h", name, dfp_resp, dfp_rdata, line);
      end
   endtask

   // Write burst: ready_mask bit c is bmem_ready during cycle c after the request edge.
   task automatic write_burst(input string name, input logic [31:0] addr, input logic [31:0] exp_aligned,
                              input logic [255:0] wdata, input logic [15:0] ready_mask,
                              input int resp_cycle, input int exp_beats);
      int k;
      int wr_cycles;
      k = 0;
      wr_cycles = 0;
      dfp_write = 1'b1;
      dfp_addr  = addr;
      dfp_wdata = wdata;
      @(posedge clk); #1;
      for (int c = 1; c <= resp_cycle; c++) begin
         bmem_ready = ready_mask[c];
         if (bmem_write === 1'b1) wr_cycles++;
         vecs++;
         if (c < resp_cycle) begin
            if (bmem_write !== 1'b1 || bmem_addr !== exp_aligned || bmem_wdata !== wdata[64*k +: 64]
                || dfp_resp !== 1'b0 || bmem_read !== 1'b0) begin
               miss++;
               $display("FAIL %s cyc%0d: got wr=%0b addr=%h wdata=%h resp=%0b rd=%0b expected 1 %h %h 0 0",
                        name, c, bmem_write, bmem_addr, bmem_wdata, dfp_resp, bmem_read, exp_aligned, wdata[64*k +: 64]);
            end
            if (ready_mask[c]) k++;
            @(posedge clk); #1;
         end else begin
            if (bmem_write !== 1'b0 || dfp_resp !== 1'b1 || k != 4) begin
               miss++;
               $display("FAIL %s resp: got wr=%0b resp=%0b beats=%0d expected 0 1 4", name, bmem_write, dfp_resp, k);
            end
         end
      end
      dfp_write = 1'b0;
      bmem_ready = 1'b1;
      vecs++;
      if (wr_cycles != exp_beats) begin
         miss++;
         $display("FAIL %s beat_cycles: got %0d expected %0d", name, wr_cycles, exp_beats);
      end
      @(posedge clk); #1;
      vecs++;
      if (dfp_resp !== 1'b0 || bmem_write !== 1'b0 || bmem_read !== 1'b0) begin
         miss++;
         $display("FAIL %s idle: got resp=%0b wr=%0b rd=%0b expected 0 0 0", name, dfp_resp, bmem_write, bmem_read);
      end
   endtask

   task automatic test_reset();
      #7;
      vecs++;
      if (dfp_resp !== 1'b0 || dfp_rdata !== 256'd0 || bmem_read !== 1'b0 || bmem_write !== 1'b0
          || bmem_addr !== 32'd0 || bmem_wdata !== 64'd0) begin
         miss++;
         $display("FAIL reset: got resp=%0b rdata=%h rd=%0b wr=%0b addr=%h wdata=%h expected all 0",
                  dfp_resp, dfp_rdata, bmem_read, bmem_write, bmem_addr, bmem_wdata);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_read();
      read_burst("read", 32'h0000_1234, 32'h0000_1220, LINE_R1, 32'h0000_1220, 1'b0);
   endtask

   task automatic test_idle_rvalid();
      bmem_rvalid = 1'b1;
      bmem_raddr  = 32'h0000_1220;
      bmem_rdata  = 64'hFFFF_0000_FFFF_0000;
      @(posedge clk); #1;
      bmem_rvalid = 1'b0;
      @(posedge clk); #1;
      vecs++;
      if (dfp_rdata !== LINE_R1 || dfp_resp !== 1'b0) begin
         miss++;
         $display("FAIL idle_rvalid: got rdata=%h resp=%0b expected %h 0", dfp_rdata, dfp_resp, LINE_R1);
      end
   endtask

   task automatic test_write();
      write_burst("write", 32'h8000_0040, 32'h8000_0040, LINE_W1, 16'hFFFF, 5, 4);
   endtask

   task automatic test_write_stall();
      write_burst("write_stall", 32'h0000_3A5F, 32'h0000_3A40, LINE_W2, 16'hFFC7, 8, 7);
   endtask

   task automatic test_back_to_back();
      dfp_read = 1'b1;
      write_burst("rw_write", 32'h0000_4000, 32'h0000_4000, LINE_W1, 16'hFFFF, 5, 4);
      read_burst("rw_read", 32'h0000_4000, 32'h0000_4000, LINE_R2, 32'h0000_4000, 1'b0);
   endtask

   task automatic test_reset_mid_read();
      dfp_read = 1'b1;
      dfp_addr = 32'h0000_2010;
      bmem_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         bmem_rvalid = 1'b1;
         bmem_raddr  = 32'h0000_2000;
         bmem_rdata  = LINE_R3[64*i +: 64];
         @(posedge clk); #1;
      end
      bmem_rvalid = 1'b0;
      #2 rst = 1'b1;
      #1;
      vecs++;
      if (dfp_resp !== 1'b0 || dfp_rdata !== 256'd0 || bmem_read !== 1'b0 || bmem_write !== 1'b0
          || bmem_addr !== 32'd0 || bmem_wdata !== 64'd0) begin
         miss++;
         $display("FAIL async_reset: got resp=%0b rdata=%h rd=%0b wr=%0b addr=%h wdata=%h expected all 0",
                  dfp_resp, dfp_rdata, bmem_read, bmem_write, bmem_addr, bmem_wdata);
      end
      dfp_read = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         vecs++;
         if (dfp_resp !== 1'b0 || bmem_read !== 1'b0) begin
            miss++;
            $display("FAIL post_reset%0d: got resp=%0b rd=%0b expected 0 0", i, dfp_resp, bmem_read);
         end
      end
      read_burst("reread", 32'h0000_2010, 32'h0000_2000, LINE_R3, 32'h0000_2000, 1'b0);
   endtask

   task automatic test_raddr();
`ifdef CLA_RADDR_CHECK_EN
      read_burst("raddr_stray", 32'h0000_5008, 32'h0000_5000, LINE_R2, 32'h0000_5000, 1'b1);
`else
      read_burst("raddr_ignored", 32'h0000_5008, 32'h0000_5000, LINE_R2, 32'hDEAD_0000, 1'b0);
`endif
   endtask

   initial begin
      rst         = 1'b1;
      dfp_addr    = '0;
      dfp_read    = 1'b0;
      dfp_write   = 1'b0;
      dfp_wdata   = '0;
      bmem_ready  = 1'b1;
      bmem_raddr  = '0;
      bmem_rdata  = '0;
      bmem_rvalid = 1'b0;
      test_reset();
      test_read();
      test_idle_rvalid();
      test_write();
      test_write_stall();
      test_back_to_back();
      test_reset_mid_read();
      test_raddr();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule
